// File: rtl/filter_pkg.sv
// filter_pkg: shared constants and the channel-index width helper for the trigger filters.
package filter_pkg;
   localparam int DEFAULT_LOOK_BACK = 50;
   localparam int DEFAULT_LOW = 2;
   localparam int DEFAULT_HIGH = 9;
   function automatic int chan_idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/multichannel_minmax_trigger_if.sv
// multichannel_minmax_trigger_if: channel-tagged sample stream (no ready, one sample per cycle max).
// Ports: axiiv sample valid, axiid unsigned sample, axiic channel index.
interface multichannel_minmax_trigger_if #(
   parameter int W = 8,
   parameter int CH_W = 3
) ();
   logic axiiv;
   logic [W-1:0] axiid;
   logic [CH_W-1:0] axiic;
   modport master (output axiiv, axiid, axiic);
   modport slave (input axiiv, axiid, axiic);
endinterface

// File: rtl/minmax_window_step.sv
// minmax_window_step: combinational next state of one channel's min/max window and hysteresis trigger.
// Ports: s_i incoming sample; *_i stored channel state; *_o next state; close_o window closes; range_o max-min.
module minmax_window_step #(
   parameter int W = 8,
   parameter int CNT_W = 1,
   parameter int HOLD_W = 1,
   parameter int LOOK_BACK = 50,
   parameter int LOW_THRESHOLD = 2,
   parameter int HIGH_THRESHOLD = 9,
   parameter int HOLDOFF_WINDOWS = 0
) (
   input  logic [W-1:0] s_i,
   input  logic [W-1:0] min_i,
   input  logic [W-1:0] max_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [HOLD_W-1:0] hold_i,
   input  logic trig_i,
   output logic [W-1:0] min_o,
   output logic [W-1:0] max_o,
   output logic [CNT_W-1:0] count_o,
   output logic [HOLD_W-1:0] hold_o,
   output logic trig_o,
   output logic close_o,
   output logic [W-1:0] range_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LOOK_BACK - 1);
   localparam logic [W-1:0] LOW_V = W'(LOW_THRESHOLD);
   localparam logic [W-1:0] HIGH_V = W'(HIGH_THRESHOLD);
   localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(HOLDOFF_WINDOWS);
   logic first, hi, lo, held;
   always_comb begin
      first = count_i == '0;
      min_o = (first || s_i < min_i) ? s_i : min_i;
      max_o = (first || s_i > max_i) ? s_i : max_i;
      close_o = count_i == LAST;
      count_o = close_o ? '0 : count_i + CNT_W'(1);
      range_o = max_o - min_o;
      hi = close_o && range_o >= HIGH_V;
      lo = range_o <= LOW_V;
      held = close_o && trig_i && hold_i != '0;
      // a high window always (re)arms, so hold-off counts from the last high window
      trig_o = hi ? 1'b1 : (close_o && trig_i && !held && lo) ? 1'b0 : trig_i;
      hold_o = hi ? HOLD_V : held ? hold_i - HOLD_W'(1) : hold_i;
   end
endmodule

// File: rtl/multichannel_minmax_trigger.sv
// multichannel_minmax_trigger: per-channel windowed peak-to-peak detector with hysteresis and hold-off.
// Ports: clk, rst (sync, active-high); adc sample stream; triggered per-channel state; any_triggered
// registered OR; range_valid/range_channel/range_value report each closed window.
module multichannel_minmax_trigger import filter_pkg::*; #(
   parameter int SAMPLE_DATA_WIDTH = 8,
   parameter int NUM_CHANNELS = 8,
   parameter int LOOK_BACK = DEFAULT_LOOK_BACK,
   parameter int LOW_THRESHOLD = DEFAULT_LOW,
   parameter int HIGH_THRESHOLD = DEFAULT_HIGH,
   parameter int HOLDOFF_WINDOWS = 0,
   localparam int CH_W = chan_idx_width(NUM_CHANNELS)
) (
   input  logic clk,
   input  logic rst,
   multichannel_minmax_trigger_if.slave adc,
   output logic [NUM_CHANNELS-1:0] triggered,
   output logic any_triggered,
   output logic range_valid,
   output logic [CH_W-1:0] range_channel,
   output logic [SAMPLE_DATA_WIDTH-1:0] range_value
);
   localparam int W = SAMPLE_DATA_WIDTH;
   localparam int CNT_W = LOOK_BACK > 1 ? $clog2(LOOK_BACK) : 1;
   localparam int HOLD_W = HOLDOFF_WINDOWS > 0 ? $clog2(HOLDOFF_WINDOWS + 1) : 1;
   localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(NUM_CHANNELS);
   typedef struct packed {
      logic [W-1:0] mn;
      logic [W-1:0] mx;
      logic [CNT_W-1:0] count;
      logic [HOLD_W-1:0] hold;
      logic trig;
   } chan_t;
   chan_t st_q [NUM_CHANNELS];
   chan_t cur, st_d;
   logic acc, close;
   logic [CH_W-1:0] sel;
   logic [W-1:0] rng;
   logic range_valid_q, any_q;
   logic [CH_W-1:0] range_channel_q;
   logic [W-1:0] range_value_q;
   assign acc = adc.axiiv && ({1'b0, adc.axiic} < NCH_V);
   // out-of-range channels never index the state array
   assign sel = acc ? adc.axiic : '0;
   assign cur = st_q[sel];
   minmax_window_step #(
      .W(W), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .LOOK_BACK(LOOK_BACK),
      .LOW_THRESHOLD(LOW_THRESHOLD), .HIGH_THRESHOLD(HIGH_THRESHOLD), .HOLDOFF_WINDOWS(HOLDOFF_WINDOWS)
   ) u_step (
      .s_i(adc.axiid), .min_i(cur.mn), .max_i(cur.mx), .count_i(cur.count), .hold_i(cur.hold), .trig_i(cur.trig),
      .min_o(st_d.mn), .max_o(st_d.mx), .count_o(st_d.count), .hold_o(st_d.hold), .trig_o(st_d.trig),
      .close_o(close), .range_o(rng)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHANNELS; i++) st_q[i] <= '0;
         range_valid_q <= 1'b0;
         range_channel_q <= '0;
         range_value_q <= '0;
         any_q <= 1'b0;
      end else begin
         if (acc) st_q[sel] <= st_d;
         range_valid_q <= acc && close;
         if (acc && close) begin
            range_channel_q <= sel;
            range_value_q <= rng;
         end
         any_q <= |triggered;
      end
   end
   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_trig
      assign triggered[g] = st_q[g].trig;
   end
   assign any_triggered = any_q;
   assign range_valid = range_valid_q;
   assign range_channel = range_channel_q;
   assign range_value = range_value_q;
endmodule

// File: tb/tb_multichannel_minmax_trigger.sv
// tb_multichannel_minmax_trigger: two instances (hold-off 0 and 2) on one stream checked against a window-queue model.
module tb_multichannel_minmax_trigger;
   localparam int NCH = 6, LB = 4, LOW = 2, HIGH = 9;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   multichannel_minmax_trigger_if #(.W(8), .CH_W(3)) bus ();
   logic [NCH-1:0] trig_a, trig_b;
   logic any_a, any_b, rv_a, rv_b;
   logic [2:0] rc_a, rc_b;
   logic [7:0] rval_a, rval_b;
   multichannel_minmax_trigger #(.SAMPLE_DATA_WIDTH(8), .NUM_CHANNELS(NCH), .LOOK_BACK(LB),
      .LOW_THRESHOLD(LOW), .HIGH_THRESHOLD(HIGH), .HOLDOFF_WINDOWS(0)) dut_a (
      .clk(clk), .rst(rst), .adc(bus), .triggered(trig_a), .any_triggered(any_a),
      .range_valid(rv_a), .range_channel(rc_a), .range_value(rval_a));
   multichannel_minmax_trigger #(.SAMPLE_DATA_WIDTH(8), .NUM_CHANNELS(NCH), .LOOK_BACK(LB),
      .LOW_THRESHOLD(LOW), .HIGH_THRESHOLD(HIGH), .HOLDOFF_WINDOWS(2)) dut_b (
      .clk(clk), .rst(rst), .adc(bus), .triggered(trig_b), .any_triggered(any_b),
      .range_valid(rv_b), .range_channel(rc_b), .range_value(rval_b));
   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   // model: each channel keeps the raw samples of its open window
   int win [NCH][$];
   int m_trig [2][NCH];
   int m_hold [2][NCH];
   int e_any [2];
   int e_rv, e_rc, e_rval;
   bit started = 0;
   function automatic int holdoff(input int d);
      return d == 0 ? 0 : 2;
   endfunction
   function automatic logic [31:0] trig_vec(input int d);
      logic [31:0] v = '0;
      for (int c = 0; c < NCH; c++) v[c] = m_trig[d][c] != 0;
      return v;
   endfunction
   always @(posedge clk) begin : model
      int c, mn, mx, r;
      started = 1;
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            win[k].delete();
            for (int d = 0; d < 2; d++) begin
               m_trig[d][k] = 0;
               m_hold[d][k] = 0;
            end
         end
         e_any = '{0, 0};
         e_rv = 0;
         e_rc = 0;
         e_rval = 0;
      end else begin
         for (int d = 0; d < 2; d++) e_any[d] = trig_vec(d) != 0 ? 1 : 0;
         e_rv = 0;
         if (bus.axiiv && int'(bus.axiic) < NCH) begin
            c = int'(bus.axiic);
            win[c].push_back(int'(bus.axiid));
            if (win[c].size() == LB) begin
               mn = 1 << 30;
               mx = -1;
               foreach (win[c][k]) begin
                  if (win[c][k] < mn) mn = win[c][k];
                  if (win[c][k] > mx) mx = win[c][k];
               end
               r = mx - mn;
               win[c].delete();
               for (int d = 0; d < 2; d++) begin
                  if (r >= HIGH) begin
                     m_trig[d][c] = 1;
                     m_hold[d][c] = holdoff(d);
                  end else if (m_trig[d][c] != 0 && m_hold[d][c] > 0) m_hold[d][c]--;
                  else if (m_trig[d][c] != 0 && r <= LOW) m_trig[d][c] = 0;
               end
               e_rv = 1;
               e_rc = c;
               e_rval = r;
            end
         end
      end
   end
   always @(negedge clk) begin
      if (started) begin
         chk("rv_a", rv_a, e_rv);
         chk("rv_b", rv_b, e_rv);
         chk("rc_a", rc_a, e_rc);
         chk("rc_b", rc_b, e_rc);
         chk("rval_a", rval_a, e_rval);
         chk("rval_b", rval_b, e_rval);
         chk("trig_a", trig_a, trig_vec(0));
         chk("trig_b", trig_b, trig_vec(1));
         chk("any_a", any_a, e_any[0]);
         chk("any_b", any_b, e_any[1]);
      end
   end
   task automatic smp(input bit v, input int c, input int d);
      @(negedge clk);
      bus.axiiv = v;
      bus.axiic = 3'(c);
      bus.axiid = 8'(d);
   endtask
   task automatic win4(input int c, input int a, input int b, input int x, input int y);
      smp(1, c, a); smp(1, c, b); smp(1, c, x); smp(1, c, y); smp(0, 0, 165);
   endtask
   initial begin
      bus.axiiv = 1'b0;
      bus.axiic = '0;
      bus.axiid = '0;
      repeat (2) @(negedge clk);
      chk("rst_rv", rv_a, 0);
      chk("rst_rval", rval_a, 0);
      chk("rst_rc", rc_a, 0);
      chk("rst_trig", trig_a, 0);
      chk("rst_any", any_a, 0);
      rst = 1'b0;
      smp(1, 0, 10); smp(0, 0, 255); smp(1, 0, 20); smp(1, 7, 255); smp(1, 0, 15); smp(1, 0, 12); smp(0, 0, 0);
      chk("t1_rv", rv_a, 1);
      chk("t1_rc", rc_a, 0);
      chk("t1_rval", rval_a, 10);
      chk("t1_model_rval", e_rval, 10);
      chk("t1_trig_a", trig_a[0], 1);
      chk("t1_trig_b", trig_b[0], 1);
      chk("t1_any_lag", any_a, 0);
      smp(0, 0, 0);
      chk("t1_any", any_a, 1);
      chk("t1_rv_pulse", rv_a, 0);
      chk("t1_rval_hold", rval_a, 10);
      win4(0, 50, 55, 52, 51);
      chk("hy_rval5", rval_a, 5);
      chk("hy_keep", trig_a[0], 1);
      win4(0, 100, 101, 100, 102);
      chk("hy_rval2", rval_a, 2);
      chk("hy_release_a", trig_a[0], 0);
      chk("hy_model_a", m_trig[0][0], 0);
      chk("hy_holdoff_b", trig_b[0], 1);
      smp(1, 0, 0); smp(1, 3, 7); smp(1, 0, 9); smp(1, 3, 7);
      smp(1, 0, 0); smp(1, 3, 7); smp(1, 0, 9); smp(1, 3, 7);
      chk("il_rv0", rv_a, 1);
      chk("il_rc0", rc_a, 0);
      chk("il_rval0", rval_a, 9);
      chk("il_trig0", trig_a[0], 1);
      smp(0, 0, 0);
      chk("il_rv3", rv_a, 1);
      chk("il_rc3", rc_a, 3);
      chk("il_rval3", rval_a, 0);
      chk("il_trig3", trig_a[3], 0);
      win4(2, 0, 12, 0, 0);
      chk("ho_rval12", rval_a, 12);
      chk("ho_trig_a", trig_a[2], 1);
      chk("ho_trig_b", trig_b[2], 1);
      for (int w = 0; w < 3; w++) begin
         win4(2, 5, 5, 5, 5);
         chk("ho_win_a", trig_a[2], 0);
         chk("ho_win_b", trig_b[2], w < 2 ? 1 : 0);
      end
      smp(1, 1, 0); smp(1, 1, 200); smp(0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_trig_a", trig_a, 0);
      chk("mr_trig_b", trig_b, 0);
      chk("mr_rv", rv_a, 0);
      chk("mr_rc", rc_a, 0);
      chk("mr_rval", rval_a, 0);
      chk("mr_any", any_a, 0);
      rst = 1'b0;
      smp(0, 0, 0);
      chk("mr_after_any", any_b, 0);
      win4(1, 5, 5, 5, 5);
      chk("mr_rv1", rv_a, 1);
      chk("mr_rc1", rc_a, 1);
      chk("mr_rval1", rval_a, 0);
      chk("mr_notrig", trig_a[1], 0);
      for (int i = 0; i < 20; i++) smp(1, 6 + (i % 2), (i % 2) ? 255 : 0);
      smp(0, 0, 0);
      chk("oor_rv", rv_a, 0);
      chk("oor_rc", rc_a, 1);
      chk("oor_trig", trig_a, 0);
      win4(5, 1, 2, 3, 4);
      chk("ch5_rc", rc_a, 5);
      chk("ch5_rval", rval_a, 3);
      repeat (2) smp(0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
